// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - operation and state encodings for the digit-serial add/sub unit
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_RSUB = 2'd2,
        OP_ADC  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_digit.sv
// rtl/addsub_digit.sv - combinational DIGIT-bit adder slice with carry into its top bit
module addsub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] full;

    assign full  = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
    assign sum   = full[DIGIT-1:0];
    assign cout  = full[DIGIT];
    // The top sum bit is x^y^carry-in, so the carry into it falls out of that relation.
    assign c_msb = x[DIGIT-1] ^ y[DIGIT-1] ^ sum[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - digit-serial add/sub/rsub/adc unit; ADDSUB_SATURATE_EN clamps o on overflow
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt;
    logic [WIDTH-1:0]        x_sr, y_sr, res_sr;
    logic                    cy;
    logic                    accept, last;
    logic [WIDTH-1:0]        op_x, op_y;
    logic                    op_cin;
    logic [DIGIT-1:0]        d_sum;
    logic                    d_cout, d_cmsb;
    logic [WIDTH+DIGIT-1:0]  res_cat;
    logic [WIDTH-1:0]        res_nxt, o_fin;
    logic                    ovf;

    assign accept = start && (state != ST_RUN);
    assign last   = (cnt == CW'(N - 1));
    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last)  state_nxt = ST_DONE;
            ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Subtraction is folded into the operands so the slice adder only ever adds.
    always_comb begin
        op_x   = a;
        op_y   = b;
        op_cin = 1'b0;
        case (select)
            OP_SUB: begin
                op_y   = ~b;
                op_cin = 1'b1;
            end
            OP_RSUB: begin
                op_x   = b;
                op_y   = ~a;
                op_cin = 1'b1;
            end
            OP_ADC:  op_cin = carry;
            default: ;
        endcase
    end

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x     (x_sr[DIGIT-1:0]),
        .y     (y_sr[DIGIT-1:0]),
        .cin   (cy),
        .sum   (d_sum),
        .cout  (d_cout),
        .c_msb (d_cmsb)
    );

    assign res_cat = {d_sum, res_sr};
    assign res_nxt = res_cat[WIDTH+DIGIT-1:DIGIT];
    assign ovf     = d_cmsb ^ d_cout;

`ifdef ADDSUB_SATURATE_EN
    always_comb begin
        o_fin = res_nxt;
        if (ovf) begin
            o_fin = res_nxt[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    assign o_fin = res_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            x_sr     <= '0;
            y_sr     <= '0;
            res_sr   <= '0;
            cy       <= 1'b0;
            o        <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            x_sr   <= op_x;
            y_sr   <= op_y;
            res_sr <= '0;
            cy     <= op_cin;
        end else if (state == ST_RUN) begin
            cnt    <= cnt + 1'b1;
            x_sr   <= x_sr >> DIGIT;
            y_sr   <= y_sr >> DIGIT;
            res_sr <= res_nxt;
            cy     <= d_cout;
            if (last) begin
                o        <= o_fin;
                carry    <= d_cout;
                overflow <= ovf;
                zero     <= (o_fin == '0);
            end
        end
    end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, multi-cycle, digit-serial add/subtract unit with a start/busy/done handshake.
- Successor to the combinational 4-bit select-driven add/sub block; adds width and digit parameters, registered results, status flags and add-with-carry chaining.
- Processes DIGIT bits per clock, LSB first, so wide operands share one small adder.
- Sits between the control sequencer and result register file.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- DIGIT, 2, bits processed per cycle; must divide WIDTH. N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when not busy
- select  in  2  operation: 0 ADD a+b, 1 SUB a-b, 2 RSUB b-a, 3 ADC a+b+C (C = stored carry flag)
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start
- busy  out  1  high while the operation runs
- done  out  1  one-cycle pulse when the result is valid
- o  out  WIDTH  result, held until the next completion
- carry  out  1  carry-out of the last completed op; for SUB/RSUB, 1 = no borrow
- overflow  out  1  two's-complement signed overflow of the last op
- zero  out  1  o == 0

Behaviour:
- Reset (async, immediate): state IDLE; busy=0, done=0, o=0, carry=0, overflow=0, zero=0; digit counter and operand shift registers cleared. Reset mid-RUN aborts the op; no done is issued.
- States: IDLE, RUN, DONE.
  - IDLE/DONE, start=1 at edge E0: latch a, b and select; state→RUN; counter=0.
  - DONE, start=0: →IDLE.
- SUB/RSUB use minuend + ~subtrahend with carry-in 1. ADD uses carry-in 0. ADC uses carry-in = carry flag as it stood at E0.
- RUN, edges E1..EN: one DIGIT slice per edge, LSB first. The carry is registered between slices. Result bits are shifted into a result register.
- At EN: o, carry, overflow and zero are updated together; state→DONE; done=1 for exactly one cycle.
- Latency: done is high in the cycle after edge E0+N, i.e. N cycles after start is sampled.
- busy=1 in RUN only. start while busy is ignored, with no queuing. Inputs a, b and select may change freely after E0.
- Back-to-back operation: start during the DONE cycle is accepted, giving a throughput of one op per N+1 cycles.
- overflow = carry into MSB XOR carry out of MSB.
- The carry flag persists across operations until reset; this is the chaining state used by ADC.
- Outputs hold their values in IDLE.

Optional Feature:
- Macro ADDSUB_SATURATE_EN.
- Defined: when overflow=1, o is clamped at completion.
  - Raw MSB=1 gives the signed max (0111..1).
  - Raw MSB=0 gives the signed min (1000..0).
  - overflow and carry still report the unclamped arithmetic.
  - zero is evaluated on the clamped o.
- Undefined: o is the wrapped modulo-2^WIDTH result.

Decomposition:
- Package addsub_pkg holds:
  - op encodings OP_ADD=2'd0, OP_SUB=2'd1, OP_RSUB=2'd2, OP_ADC=2'd3
  - state encoding ST_IDLE, ST_RUN, ST_DONE
- Sub-module addsub_digit: combinational DIGIT-bit ripple adder.
  - Inputs: x, y, cin.
  - Outputs: sum, cout, and c_msb (carry into its top bit), used for overflow on the final slice.

Test Plan (WIDTH=8, DIGIT=2, N=4):
1. ADD a=100, b=27, start at E0 → done at E0+4; o=127, carry=0, overflow=0, zero=0; busy high for 4 cycles.
2. ADD a=100, b=28 → o=0x80, overflow=1, carry=0. With ADDSUB_SATURATE_EN: o=0x7F, overflow=1.
3. SUB a=5, b=7 → o=0xFE, carry=0, overflow=0. Then RSUB a=5, b=7 → o=2, carry=1.
4. SUB a=7, b=7 → o=0, zero=1, carry=1. Then SUB a=0x80, b=0x01 → o=0x7F, overflow=1.
5. Chaining: ADD 0xFF+0x01 → o=0, carry=1, zero=1. Then start in the DONE cycle with ADC 0x00+0x00 → o=1, carry=0.
6. Start ADD 3+4; pulse start with other operands during RUN → ignored, o=7. Next op: rst_n low at RUN cycle 2 → busy, done, o and flags all 0 immediately; no done after release.
